// File: rtl/regfile_wb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the write-back request ports, the issue port, the read-decode hazard
// lookup, the registered register-file write port and the busy scoreboard of
// regfile_wb_arbiter.
//   master : the pipeline side (drives requests, issue and read addresses)
//   slave  : the arbiter side (drives grants, hazards, write port, scoreboard)
// Optional macro WB_BYPASS_EN adds the forwarding signals fwd_a/fwd_b/fwd_data.
// ----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int SIZE = 64,
  parameter int ADDR = 5
);
  localparam int NUMB = 1 << ADDR;

  logic            req0_valid;
  logic [ADDR-1:0] req0_addr;
  logic [SIZE-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [ADDR-1:0] req1_addr;
  logic [SIZE-1:0] req1_data;
  logic            req1_ready;
  logic            iss_valid;
  logic [ADDR-1:0] iss_addr;
  logic            iss_ready;
  logic [ADDR-1:0] rd_addr_a;
  logic [ADDR-1:0] rd_addr_b;
  logic            hazard_a;
  logic            hazard_b;
  logic            Write_en;
  logic [ADDR-1:0] W_Addr;
  logic [SIZE-1:0] W_Data;
  logic [NUMB-1:0] busy_vec;
`ifdef WB_BYPASS_EN
  logic            fwd_a;
  logic            fwd_b;
  logic [SIZE-1:0] fwd_data;
`endif

  modport master (
`ifdef WB_BYPASS_EN
    input  fwd_a, input fwd_b, input fwd_data,
`endif
    output req0_valid, output req0_addr, output req0_data, input req0_ready,
    output req1_valid, output req1_addr, output req1_data, input req1_ready,
    output iss_valid, output iss_addr, input iss_ready,
    output rd_addr_a, output rd_addr_b, input hazard_a, input hazard_b,
    input  Write_en, input W_Addr, input W_Data, input busy_vec
  );

  modport slave (
`ifdef WB_BYPASS_EN
    output fwd_a, output fwd_b, output fwd_data,
`endif
    input  req0_valid, input req0_addr, input req0_data, output req0_ready,
    input  req1_valid, input req1_addr, input req1_data, output req1_ready,
    input  iss_valid, input iss_addr, output iss_ready,
    input  rd_addr_a, input rd_addr_b, output hazard_a, output hazard_b,
    output Write_en, output W_Addr, output W_Data, output busy_vec
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Two-requester round-robin write-back arbiter in front of a register file,
// with a pending-write scoreboard used for read-operand hazard detection.
// Ports:
//   Clk  : single clock, all state updates on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_wb_arbiter_if.slave (requests/grants, issue port, hazard
//          lookup, registered write port, busy_vec scoreboard)
// Optional macro WB_BYPASS_EN: forwards the registered write port to the read
// decode stage (fwd_a/fwd_b/fwd_data) and suppresses the matching hazard.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int SIZE = 64,
  parameter int ADDR = 5
) (
  input logic                  Clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NUMB = 1 << ADDR;
  localparam logic [ADDR-1:0] ZERO_ADDR = {ADDR{1'b0}};

  logic            rr_ptr_r;
  logic            we_r;
  logic [ADDR-1:0] wa_r;
  logic [SIZE-1:0] wd_r;
  logic [NUMB-1:0] busy_r;

  logic            gnt0_s;
  logic            gnt1_s;
  logic            contended_s;
  logic [ADDR-1:0] win_addr_s;
  logic [SIZE-1:0] win_data_s;
  logic            iss_ready_s;
  logic            iss_fire_s;
  logic [NUMB-1:0] busy_next_s;
  logic            fwd_a_s;
  logic            fwd_b_s;

  // Grant selection: a lone requester wins outright, rr_ptr breaks ties.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    contended_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
    end else if (bus.req0_valid && bus.req1_valid) begin
      contended_s = 1'b1;
      if (rr_ptr_r) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else begin
      gnt0_s = bus.req0_valid;
      gnt1_s = bus.req1_valid;
    end
  end

  // Winner payload mux.
  always_comb begin
    if (gnt1_s) begin
      win_addr_s = bus.req1_addr;
      win_data_s = bus.req1_data;
    end else begin
      win_addr_s = bus.req0_addr;
      win_data_s = bus.req0_data;
    end
  end

  // Issue acceptance: a busy register may be reissued in the cycle its pending
  // write retires, since the new producer takes over the busy bit.
  always_comb begin
    iss_ready_s = 1'b0;
    if (rst) begin
      iss_ready_s = 1'b0;
    end else if (bus.iss_addr == ZERO_ADDR) begin
      iss_ready_s = 1'b1;
    end else if (!busy_r[bus.iss_addr]) begin
      iss_ready_s = 1'b1;
    end else if (we_r && (wa_r == bus.iss_addr)) begin
      iss_ready_s = 1'b1;
    end else begin
      iss_ready_s = 1'b0;
    end
  end

  assign iss_fire_s = bus.iss_valid && iss_ready_s && (bus.iss_addr != ZERO_ADDR);

  // Scoreboard next state: clear retiring write first so a same-cycle set wins.
  always_comb begin
    busy_next_s = busy_r;
    if (we_r) begin
      busy_next_s[wa_r] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (iss_fire_s) begin
      busy_next_s[bus.iss_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Forwarding match against the registered write port.
  always_comb begin
`ifdef WB_BYPASS_EN
    fwd_a_s = we_r && (wa_r == bus.rd_addr_a) && (bus.rd_addr_a != ZERO_ADDR);
    fwd_b_s = we_r && (wa_r == bus.rd_addr_b) && (bus.rd_addr_b != ZERO_ADDR);
`else
    fwd_a_s = 1'b0;
    fwd_b_s = 1'b0;
`endif
  end

  // Round-robin pointer: hand priority to the loser after a contended grant.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= 1'b0;
    end else if (contended_s) begin
      rr_ptr_r <= ~rr_ptr_r;
    end
  end

  // Registered write port; address-0 transfers are consumed without a write.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      we_r <= 1'b0;
      wa_r <= {ADDR{1'b0}};
      wd_r <= {SIZE{1'b0}};
    end else begin
      we_r <= (gnt0_s || gnt1_s) && (win_addr_s != ZERO_ADDR);
      if (gnt0_s || gnt1_s) begin
        wa_r <= win_addr_s;
        wd_r <= win_data_s;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUMB{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;
  assign bus.iss_ready  = iss_ready_s;
  assign bus.hazard_a   = busy_r[bus.rd_addr_a] && (bus.rd_addr_a != ZERO_ADDR) && !fwd_a_s;
  assign bus.hazard_b   = busy_r[bus.rd_addr_b] && (bus.rd_addr_b != ZERO_ADDR) && !fwd_b_s;
  assign bus.Write_en   = we_r;
  assign bus.W_Addr     = wa_r;
  assign bus.W_Data     = wd_r;
  assign bus.busy_vec   = busy_r;
`ifdef WB_BYPASS_EN
  assign bus.fwd_a      = fwd_a_s;
  assign bus.fwd_b      = fwd_b_s;
  assign bus.fwd_data   = wd_r;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed scenarios plus a randomized run checked against a behavioural model
// (favoured requester, per-register pending flags, one-cycle-late write port).
// Inputs change on the falling edge; combinational outputs are sampled 1 time
// unit later, registered outputs 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int SIZE = 64;
  localparam int ADDR = 5;
  localparam int NUMB = 1 << ADDR;

  logic Clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.SIZE(SIZE), .ADDR(ADDR)) bus ();

  regfile_wb_arbiter #(.SIZE(SIZE), .ADDR(ADDR)) dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.iss_valid  = 1'b0; bus.iss_addr  = '0;
    bus.rd_addr_a  = '0;   bus.rd_addr_b = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    #3;
    checks++;
    if (bus.Write_en !== 1'b0 || bus.W_Addr !== 5'd0 || bus.W_Data !== 64'd0) begin
      errors++; $display("FAIL reset_wport: got we=%b wa=%0d wd=%0h want 0", bus.Write_en, bus.W_Addr, bus.W_Data);
    end
    checks++;
    if (bus.busy_vec !== 32'd0) begin
      errors++; $display("FAIL reset_busy: got %h want 0", bus.busy_vec);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.iss_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b%b want 000", bus.req0_ready, bus.req1_ready, bus.iss_ready);
    end
    @(posedge Clk);
    #1;
    checks++;
    if (bus.Write_en !== 1'b0 || bus.busy_vec !== 32'd0) begin
      errors++; $display("FAIL reset_hold: got we=%b busy=%h want 0", bus.Write_en, bus.busy_vec);
    end
    apply_reset();
  endtask

  task automatic test_single_grant();
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 64'hA5;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.Write_en !== 1'b1 || bus.W_Addr !== 5'd5 || bus.W_Data !== 64'hA5) begin
      errors++; $display("FAIL single_write: got we=%b wa=%0d wd=%0h want 1 5 a5", bus.Write_en, bus.W_Addr, bus.W_Data);
    end
    @(negedge Clk);
    clear_inputs();
    @(posedge Clk); #1;
    checks++;
    if (bus.Write_en !== 1'b0) begin
      errors++; $display("FAIL single_once: got we=%b want 0", bus.Write_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_addr;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 64'h10;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 64'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL b2b_grant%0d: got %b%b want %b%b", i, bus.req0_ready, bus.req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      exp_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
      @(posedge Clk); #1;
      checks++;
      if (bus.Write_en !== 1'b1 || bus.W_Addr !== exp_addr) begin
        errors++; $display("FAIL b2b_write%0d: got we=%b wa=%0d want 1 %0d", i, bus.Write_en, bus.W_Addr, exp_addr);
      end
      @(negedge Clk);
    end
    clear_inputs();
  endtask

  task automatic test_hazard_clear();
    apply_reset();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
    #1;
    checks++;
    if (bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL haz_iss_ready: got %b want 1", bus.iss_ready);
    end
    @(negedge Clk);
    bus.iss_valid = 1'b0; bus.rd_addr_a = 5'd7;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 64'h77;
    #1;
    checks++;
    if (bus.hazard_a !== 1'b1 || bus.busy_vec[7] !== 1'b1 || bus.req1_ready !== 1'b1) begin
      errors++; $display("FAIL haz_set: got haz=%b busy7=%b rdy1=%b want 111", bus.hazard_a, bus.busy_vec[7], bus.req1_ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.Write_en !== 1'b1 || bus.W_Addr !== 5'd7 || bus.busy_vec[7] !== 1'b1) begin
      errors++; $display("FAIL haz_wcycle: got we=%b wa=%0d busy7=%b want 1 7 1", bus.Write_en, bus.W_Addr, bus.busy_vec[7]);
    end
`ifndef WB_BYPASS_EN
    checks++;
    if (bus.hazard_a !== 1'b1) begin
      errors++; $display("FAIL haz_during_write: got %b want 1", bus.hazard_a);
    end
`endif
    @(negedge Clk);
    bus.req1_valid = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (bus.busy_vec[7] !== 1'b0 || bus.hazard_a !== 1'b0) begin
      errors++; $display("FAIL haz_cleared: got busy7=%b haz=%b want 0 0", bus.busy_vec[7], bus.hazard_a);
    end
    @(negedge Clk);
    clear_inputs();
  endtask

  task automatic test_issue_during_clear();
    apply_reset();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    @(negedge Clk);
    bus.iss_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 64'h33;
    @(negedge Clk);
    bus.req0_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    #1;
    checks++;
    if (bus.Write_en !== 1'b1 || bus.W_Addr !== 5'd3 || bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL reissue_ready: got we=%b wa=%0d iss_rdy=%b want 1 3 1", bus.Write_en, bus.W_Addr, bus.iss_ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.busy_vec !== 32'h0000_0008) begin
      errors++; $display("FAIL reissue_busy: got %h want 00000008", bus.busy_vec);
    end
    @(negedge Clk);
    clear_inputs();
  endtask

  task automatic test_addr_zero();
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 64'hFF;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0; bus.rd_addr_a = 5'd0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.iss_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready: got rdy0=%b iss=%b want 1 1", bus.req0_ready, bus.iss_ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.Write_en !== 1'b0 || bus.busy_vec !== 32'd0 || bus.hazard_a !== 1'b0) begin
      errors++; $display("FAIL zero_nowrite: got we=%b busy=%h haz=%b want 0 0 0", bus.Write_en, bus.busy_vec, bus.hazard_a);
    end
    @(negedge Clk);
    clear_inputs();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    @(negedge Clk);
    bus.iss_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 64'h1234;
    @(negedge Clk);
    bus.req0_valid = 1'b0; bus.rd_addr_b = 5'd9; bus.rd_addr_a = 5'd0;
    #1;
    checks++;
    if (bus.fwd_b !== 1'b1 || bus.fwd_data !== 64'h1234 || bus.hazard_b !== 1'b0 || bus.fwd_a !== 1'b0) begin
      errors++; $display("FAIL bypass: got fwd_b=%b data=%h haz_b=%b fwd_a=%b want 1 1234 0 0", bus.fwd_b, bus.fwd_data, bus.hazard_b, bus.fwd_a);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.fwd_b !== 1'b0 || bus.hazard_b !== 1'b0) begin
      errors++; $display("FAIL bypass_after: got fwd_b=%b haz_b=%b want 0 0", bus.fwd_b, bus.hazard_b);
    end
    @(negedge Clk);
    clear_inputs();
  endtask
`endif

  task automatic test_reset_mid_transfer();
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 64'h55;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
    @(posedge Clk); #1;
    checks++;
    if (bus.Write_en !== 1'b1 || bus.busy_vec[12] !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got we=%b busy12=%b want 1 1", bus.Write_en, bus.busy_vec[12]);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Write_en !== 1'b0 || bus.W_Addr !== 5'd0 || bus.W_Data !== 64'd0 || bus.busy_vec !== 32'd0) begin
      errors++; $display("FAIL midrst_async: got we=%b wa=%0d wd=%h busy=%h want 0", bus.Write_en, bus.W_Addr, bus.W_Data, bus.busy_vec);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.iss_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready: got rdy0=%b iss=%b want 0 0", bus.req0_ready, bus.iss_ready);
    end
    @(negedge Clk);
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_random();
    bit         busy_m [NUMB];
    int         favour;
    bit         exp_we;
    logic [4:0] exp_wa;
    logic [63:0] exp_wd;
    bit         v0, v1, iv, e0, e1, e_iss, e_ha, e_hb, byp_a, byp_b;
    logic [4:0] a0, a1, ia, ra, rb;
    logic [63:0] d0, d1;
    logic [31:0] exp_busy;
    apply_reset();
    favour = 0; exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    for (int k = 0; k < NUMB; k++) busy_m[k] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1)); iv = 1'($urandom_range(0, 1));
      a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
      ia = 5'($urandom_range(0, 7)); ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
      bus.iss_valid = iv; bus.iss_addr = ia; bus.rd_addr_a = ra; bus.rd_addr_b = rb;
      #1;
      if (v0 && v1) begin e0 = (favour == 0); e1 = (favour == 1); end
      else begin e0 = v0; e1 = v1; end
      checks++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== e1) begin
        errors++; $display("FAIL rnd_grant@%0d: got %b%b want %b%b", n, bus.req0_ready, bus.req1_ready, e0, e1);
      end
      e_iss = (ia == 5'd0) || !busy_m[ia] || (exp_we && exp_wa == ia);
      checks++;
      if (bus.iss_ready !== e_iss) begin
        errors++; $display("FAIL rnd_iss@%0d: got %b want %b", n, bus.iss_ready, e_iss);
      end
      byp_a = 1'b0; byp_b = 1'b0;
`ifdef WB_BYPASS_EN
      byp_a = exp_we && exp_wa == ra && ra != 5'd0;
      byp_b = exp_we && exp_wa == rb && rb != 5'd0;
`endif
      e_ha = busy_m[ra] && !byp_a;
      e_hb = busy_m[rb] && !byp_b;
      checks++;
      if (bus.hazard_a !== e_ha || bus.hazard_b !== e_hb) begin
        errors++; $display("FAIL rnd_hazard@%0d: got %b%b want %b%b", n, bus.hazard_a, bus.hazard_b, e_ha, e_hb);
      end
      if (exp_we) busy_m[exp_wa] = 1'b0;
      if (iv && e_iss && ia != 5'd0) busy_m[ia] = 1'b1;
      if (e1) begin exp_we = (a1 != 5'd0); exp_wa = a1; exp_wd = d1; end
      else if (e0) begin exp_we = (a0 != 5'd0); exp_wa = a0; exp_wd = d0; end
      else exp_we = 1'b0;
      if (v0 && v1) favour = 1 - favour;
      @(posedge Clk); #1;
      checks++;
      if (bus.Write_en !== exp_we || (exp_we && (bus.W_Addr !== exp_wa || bus.W_Data !== exp_wd))) begin
        errors++; $display("FAIL rnd_write@%0d: got we=%b wa=%0d wd=%h want %b %0d %h", n, bus.Write_en, bus.W_Addr, bus.W_Data, exp_we, exp_wa, exp_wd);
      end
      for (int k = 0; k < NUMB; k++) exp_busy[k] = busy_m[k];
      checks++;
      if (bus.busy_vec !== exp_busy) begin
        errors++; $display("FAIL rnd_busy@%0d: got %h want %h", n, bus.busy_vec, exp_busy);
      end
    end
    @(negedge Clk);
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    clear_inputs();
    @(negedge Clk);
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_hazard_clear();
    test_issue_during_clear();
    test_addr_zero();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid_transfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: SIZE, 64, data width; ADDR, 5, register address width (NUMB = 1<<ADDR registers).
REQ-002 Clk input 1: single clock; all state SHALL update on posedge Clk.
REQ-003 rst input 1: asynchronous, active-high reset.
REQ-004 req0_valid/req1_valid input 1 each: write-back request from requester 0 (ALU) and requester 1 (load unit).
REQ-005 req0_addr/req1_addr input ADDR each: destination register.
REQ-006 req0_data/req1_data input SIZE each: write-back data.
REQ-007 req0_ready/req1_ready output 1 each: grant; a transfer occurs in a cycle where valid and ready are both high.
REQ-008 iss_valid input 1, iss_addr input ADDR, iss_ready output 1: issue port marking a destination register pending.
REQ-009 rd_addr_a/rd_addr_b input ADDR: read addresses being decoded.
REQ-010 hazard_a/hazard_b output 1: the corresponding read register has a pending write.
REQ-011 Write_en output 1, W_Addr output ADDR, W_Data output SIZE: registered register-file write port.
REQ-012 busy_vec output NUMB: scoreboard, bit i set = register i pending.

Function
REQ-013 Ready SHALL be combinational from valid and the round-robin pointer; at most one of req0_ready/req1_ready SHALL be high per cycle.
REQ-014 Single valid requester SHALL be granted the same cycle; with both valid, the requester indicated by rr_ptr SHALL win.
REQ-015 rr_ptr SHALL toggle to the non-winner only after a contended grant; uncontended grants SHALL leave it unchanged.
REQ-016 A granted transfer SHALL appear on Write_en/W_Addr/W_Data exactly one posedge later, held for one cycle; Write_en SHALL be low in cycles with no prior-cycle grant.
REQ-017 A transfer to address 0 SHALL be granted and consumed but SHALL produce Write_en=0 and SHALL not touch busy_vec.
REQ-018 iss_ready SHALL be high when iss_addr is not busy, or is 0, or is being cleared that cycle by a registered write with Write_en=1.
REQ-019 Accepted issue (iss_valid & iss_ready, addr≠0) SHALL set busy_vec[iss_addr] at next posedge.
REQ-020 busy_vec[W_Addr] SHALL clear at the posedge ending a cycle with Write_en=1.
REQ-021 Simultaneous set and clear of the same bit SHALL leave it set (new producer wins).
REQ-022 busy_vec[0] SHALL be constant 0.
REQ-023 hazard_x SHALL equal busy_vec[rd_addr_x], combinational; rd_addr_x=0 SHALL give hazard_x=0.
REQ-024 Requests to a non-busy register SHALL still be granted (no scoreboard check on write side).

Reset
REQ-025 rst high SHALL immediately force Write_en=0, W_Addr=0, W_Data=0, busy_vec=0, rr_ptr=0 (requester 0 first), independent of Clk.
REQ-026 While rst is high, req0_ready, req1_ready and iss_ready SHALL be 0; a transfer in flight at reset assertion SHALL be discarded.

Configuration
REQ-027 Macro WB_BYPASS_EN SHALL, when defined, add outputs fwd_a/fwd_b (1) and fwd_data (SIZE): fwd_x=1 when Write_en=1 and W_Addr=rd_addr_x≠0, fwd_data=W_Data, and hazard_x forced 0 in that cycle.
REQ-028 Without WB_BYPASS_EN those ports SHALL not exist and hazard_x SHALL follow REQ-023 only.

Verification
REQ-029 Reset then req0 valid addr 5 data 0xA5 alone -> req0_ready=1 same cycle; next cycle Write_en=1, W_Addr=5, W_Data=0xA5.
REQ-030 Both valid for 4 cycles from reset -> grants 0,1,0,1; Write_en high 4 consecutive cycles.
REQ-031 Issue addr 7, then rd_addr_a=7 -> hazard_a=1; req1 writes addr 7 -> busy_vec[7] clears at the posedge ending the Write_en cycle, hazard_a=0 after.
REQ-032 Issue addr 3 in the cycle Write_en=1,W_Addr=3 -> iss_ready=1, busy_vec[3] remains 1.
REQ-033 req0 write addr 0 data 0xFF -> ready=1, Write_en stays 0; issue addr 0 -> busy_vec unchanged.
REQ-034 With WB_BYPASS_EN, Write_en=1 W_Addr=9 W_Data=0x1234, rd_addr_b=9 -> fwd_b=1, fwd_data=0x1234, hazard_b=0; rst pulse mid-transfer -> Write_en=0 immediately.
